spi_rx: RTL
===========

Name: spi_rx

Overview:
- SPI receiver (MOSI sink) for the mode-0, MSB-first, clock-gated serial link the team's SPI transmitter drives. spi_clk idles low and runs only during a byte; there is no chip select.
- Both serial inputs are oversampled in the clk domain through synchronisers, and bits are sampled on detected spi_clk rising edges.
- Completed words go to a holding register with a valid/ack handshake.
- Byte framing is by bit count; an inactivity timeout discards partial words.

Parameters:
- DATA_W, 8, bits per word.
- SYNC_STAGES, 2, flip-flop stages on spi_clk and spi_data (minimum 2).
- TIMEOUT, 64, clk cycles without a spi_clk rising edge before a partial word is discarded (minimum 4).

Ports:
- clk  input  1  system clock (100 MHz).
- reset_n  input  1  asynchronous active-low reset.
- spi_clk  input  1  serial clock from transmitter, idle low, asynchronous to clk.
- spi_data  input  1  MOSI serial data, MSB first.
- data_ack  input  1  consumer acknowledges data_out; clears data_valid.
- data_out  output  DATA_W  last completed word.
- data_valid  output  1  high from word completion until acknowledged.
- overrun  output  1  one-cycle pulse: a word completed while data_valid was high.
- frame_err  output  1  one-cycle pulse: timeout with a partial word held.
- busy  output  1  high while in RECV.

Behaviour:
- Reset: one clock; reset_n is asynchronous and active-low, and when low forces all flops to zero: data_out=0, data_valid=0, overrun=0, frame_err=0, busy=0, state=IDLE, bit_cnt=0, timeout counter=0.
  - Reset mid-word discards the partial word silently, with no frame_err.
- Synchronisers:
  - spi_clk and spi_data each pass through SYNC_STAGES flops.
  - A further flop on synced spi_clk gives a rise pulse: synced=1 and previous=0.
  - Data is taken from the synced spi_data in the same cycle as the rise pulse, so both paths have equal depth.
- Input timing requirement: spi_clk high and low phases each last at least SYNC_STAGES+1 clk cycles. spi_data is stable across each rising edge by the same margin.
- States:
  - IDLE: bit_cnt=0, busy=0.
    - On rise: shift in the bit, bit_cnt=1, go to RECV.
  - RECV: busy=1.
    - On rise: shift_reg <= {shift_reg[DATA_W-2:0], bit}; bit_cnt increments; timeout counter clears.
    - When the rise carries bit DATA_W: data_out <= assembled word (including this bit), data_valid <= 1, bit_cnt <= 0, go to IDLE.
    - No rise: timeout counter increments. When it reaches TIMEOUT-1: pulse frame_err, clear bit_cnt and shift_reg, go to IDLE.
- Latency: raw spi_clk rising edge of the last bit to data_valid high is SYNC_STAGES+1 clk edges (3 at default).
- Back-to-back words: the first rise of the next word may arrive in the cycle after completion; IDLE accepts it with no gap.
- Handshake:
  - data_valid stays high until a cycle with data_ack=1, then clears on the next edge.
  - data_ack while data_valid=0 is ignored.
- Overrun:
  - Word completes while data_valid=1 and data_ack=0: data_out is overwritten with the new word, data_valid stays 1, overrun pulses for one cycle.
  - Completion and data_ack in the same cycle: new word loaded, data_valid stays 1, no overrun.
- Timeout counter width is clog2(TIMEOUT). It saturates and is unused in IDLE; no frame_err is raised from IDLE.
- Glitch-free assumption: spi_clk pulses shorter than the timing requirement are out of scope.

Test Plan:
- Reset, then send 0xA5 at 10 MHz spi_clk (5 clk/phase): data_valid rises 3 clk after the 8th spi_clk rise, data_out=0xA5, busy high from first synced edge until completion; hold data_ack low, data_valid stays 1; pulse data_ack, data_valid=0 next cycle.
- Send 0x3C then 0xFF back-to-back, acking each within 10 clk: two valid assertions with data_out 0x3C then 0xFF, no overrun, no frame_err.
- Send 0x12 without ack, then 0x34: overrun pulses exactly once at the second completion, data_out=0x34, data_valid=1.
- Send 5 bits of 0xF0, stop spi_clk for 64 clk: frame_err pulses once, busy=0. Then send 0x81: data_out=0x81, with no stale bits.
- Assert data_ack in the exact completion cycle of a second word while the first is valid: data_valid=1, data_out=new word, overrun=0.
- Assert reset_n low asynchronously mid-word after 4 bits: all outputs 0 immediately; after release, a full 0x5A is received correctly with no frame_err.

Source files
------------

// File: rtl/spi_rx.sv
// spi_rx: mode-0 MSB-first SPI receiver with synchronised inputs, valid/ack holding register and inactivity timeout.
module spi_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              spi_data,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_prev, rise, bit_in, done;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [DATA_W-1:0] shift, shift_n, data_out_n;
  logic data_valid_n, overrun_n, frame_err_n;
  // data and clock pass through equally deep chains so the sampled bit lines up with the rise pulse
  assign rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign bit_in = dat_sync[SYNC_STAGES-1];
  assign busy   = state == RECV;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync   <= '0;
      dat_sync   <= '0;
      clk_prev   <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      tmo        <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      dat_sync   <= {dat_sync[SYNC_STAGES-2:0], spi_data};
      clk_prev   <= clk_sync[SYNC_STAGES-1];
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      tmo        <= tmo_n;
      shift      <= shift_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      overrun    <= overrun_n;
      frame_err  <= frame_err_n;
    end
  end
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    tmo_n       = tmo;
    shift_n     = shift;
    done        = 1'b0;
    frame_err_n = 1'b0;
    if (state == IDLE) begin
      bit_cnt_n = '0;
      tmo_n     = '0;
      if (rise) begin
        shift_n   = {shift[DATA_W-2:0], bit_in};
        bit_cnt_n = CW'(1);
        state_n   = RECV;
      end
    end else if (rise) begin
      shift_n = {shift[DATA_W-2:0], bit_in};
      tmo_n   = '0;
      if (bit_cnt == CW'(DATA_W - 1)) begin
        done      = 1'b1;
        bit_cnt_n = '0;
        state_n   = IDLE;
      end else begin
        bit_cnt_n = bit_cnt + 1'b1;
      end
    end else if (tmo == TW'(TIMEOUT - 1)) begin
      frame_err_n = 1'b1;
      bit_cnt_n   = '0;
      shift_n     = '0;
      tmo_n       = '0;
      state_n     = IDLE;
    end else begin
      tmo_n = tmo + 1'b1;
    end
    data_out_n   = done ? {shift[DATA_W-2:0], bit_in} : data_out;
    data_valid_n = done | (data_valid & ~data_ack);
    overrun_n    = done & data_valid & ~data_ack;
  end
endmodule
